// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: FSM state encoding and
// the width helpers used to size channel indices.
package edge_event_arbiter_pkg;

  // Two-state grant FSM: waiting for a pending channel, or offering one.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Channel index width: never narrower than one bit.
  function automatic int idw_f(input int n);
    return (clog2_f(n) < 1) ? 1 : clog2_f(n);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request at or above ptr,
// wrapping back to index 0. Purely combinational.
module rr_pick
  import edge_event_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = idw_f(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  int w_j;

  // Scan offsets from the far end down so the nearest request to ptr wins.
  always_comb begin
    any = 1'b0;
    idx = {IDW{1'b0}};
    w_j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      w_j = (w_j >= N) ? (w_j - N) : w_j;
      any = any | req[w_j];
      idx = req[w_j] ? IDW'(w_j) : idx;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: detects rising edges on N level inputs, latches them
// as pending events and hands them one at a time, round-robin, to a single
// consumer over a valid/ready handshake. A new edge on a channel that is
// still pending (and not leaving on that edge) is recorded as an overrun.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = idw_f(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   entrada,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic           clr_overrun
);

  logic [N-1:0]   r_prev;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_overrun;
  state_t         r_state;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_taken;
  logic [N-1:0]   w_pending_nxt;
  logic [N-1:0]   w_overrun_nxt;
  logic           w_xfer;
  logic           w_any;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_ptr_nxt;

  // A transfer only exists while an event is actually being offered.
  assign w_rise = entrada & ~r_prev;
  assign w_xfer = r_valid & evt_ready;

  // One-hot mask of the channel leaving on this edge (all zero if none).
  always_comb begin
    w_taken = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_taken[i] = w_xfer & (r_id == IDW'(i));
    end
  end

  // A rise coinciding with its own channel's transfer re-arms pending
  // instead of being counted as lost; an overrun set beats a clear.
  assign w_pending_nxt = (r_pending & ~w_taken) | w_rise;
  assign w_overrun_nxt = (clr_overrun ? {N{1'b0}} : r_overrun)
                       | (w_rise & r_pending & ~w_taken);

  // Next search start is the channel just after the one granted.
  assign w_ptr_nxt = (r_id == IDW'(N - 1)) ? {IDW{1'b0}} : (r_id + IDW'(1));

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req (r_pending),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Edge history and per-channel pending/overrun flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev    <= {N{1'b0}};
      r_pending <= {N{1'b0}};
      r_overrun <= {N{1'b0}};
    end else begin
      r_prev    <= entrada;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Grant FSM: pick a pending channel, then hold the offer until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= {IDW{1'b0}};
      r_ptr   <= {IDW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id    <= w_idx;
            r_valid <= 1'b1;
            r_state <= ST_OFFER;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            r_state <= ST_IDLE;
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule
